// File: rtl/practica_fsm_pkg.sv
// Shared constants for the six-state bidirectional sequence generator:
// default state codes, state indices, direction encoding and widths.
package practica_fsm_pkg;

  localparam int CODE_W = 4;
  localparam int SEQ_W  = CODE_W + 1;
  localparam int IDX_W  = 3;

  typedef enum logic [IDX_W-1:0] {
    IDX_S0 = 3'd0,
    IDX_S1 = 3'd1,
    IDX_S2 = 3'd2,
    IDX_S3 = 3'd3,
    IDX_S4 = 3'd4,
    IDX_S5 = 3'd5
  } state_e;

  localparam logic [IDX_W-1:0] IDX_LAST = 3'd5;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [CODE_W-1:0] DEF_S0 = 4'b0000;
  localparam logic [CODE_W-1:0] DEF_S1 = 4'b0010;
  localparam logic [CODE_W-1:0] DEF_S2 = 4'b0011;
  localparam logic [CODE_W-1:0] DEF_S3 = 4'b0101;
  localparam logic [CODE_W-1:0] DEF_S4 = 4'b0111;
  localparam logic [CODE_W-1:0] DEF_S5 = 4'b1010;

endpackage

// File: rtl/practica_fsm_if.sv
// Control/output bundle of practica_fsm: step controls in, registered {dir, code} out.
interface practica_fsm_if
  import practica_fsm_pkg::*;
();

  logic             enable;
  logic             up_down;
  logic [SEQ_W-1:0] seq;

  modport master (output enable, output up_down, input seq);
  modport slave  (input enable, input up_down, output seq);

endinterface

// File: rtl/practica_fsm_next.sv
// Combinational next-index/next-direction logic with ring wrap.
// Illegal index handling depends on PRACTICA_FSM_ILLEGAL_RECOVER_EN.
module practica_fsm_next
  import practica_fsm_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             enable_i,
  input  logic             up_down_i,
  input  logic             dir_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             dir_o
);

  always_comb begin
    idx_o = idx_i;
    dir_o = dir_i;
    if (idx_i > IDX_LAST) begin
      // Out-of-ring index: either snap back to S0 or park there indefinitely
`ifdef PRACTICA_FSM_ILLEGAL_RECOVER_EN
      idx_o = IDX_S0;
`else
      idx_o = idx_i;
`endif
    end else if (enable_i) begin
      dir_o = up_down_i;
      if (up_down_i == DIR_UP) begin
        idx_o = (idx_i == IDX_LAST) ? IDX_S0 : idx_i + 3'd1;
      end else begin
        idx_o = (idx_i == IDX_S0) ? IDX_LAST : idx_i - 3'd1;
      end
    end
  end

endmodule

// File: rtl/practica_fsm.sv
// Six-state bidirectional sequence generator; seq = {dir, code} straight from flops.
// Optional illegal-index recovery: define PRACTICA_FSM_ILLEGAL_RECOVER_EN.
module practica_fsm
  import practica_fsm_pkg::*;
#(
  parameter logic [CODE_W-1:0] S0 = DEF_S0,
  parameter logic [CODE_W-1:0] S1 = DEF_S1,
  parameter logic [CODE_W-1:0] S2 = DEF_S2,
  parameter logic [CODE_W-1:0] S3 = DEF_S3,
  parameter logic [CODE_W-1:0] S4 = DEF_S4,
  parameter logic [CODE_W-1:0] S5 = DEF_S5
) (
  input  logic           clk,
  input  logic           rst,
  practica_fsm_if.slave  bus
);

  logic [IDX_W-1:0]  idx_q,  idx_d;
  logic              dir_q,  dir_d;
  logic [CODE_W-1:0] code_q, code_d;

  practica_fsm_next u_next (
    .idx_i     (idx_q),
    .enable_i  (bus.enable),
    .up_down_i (bus.up_down),
    .dir_i     (dir_q),
    .idx_o     (idx_d),
    .dir_o     (dir_d)
  );

  // Code is looked up from the next index so it lands in the same edge as the index
  always_comb begin
    code_d = '0;
    case (idx_d)
      IDX_S0:  code_d = S0;
      IDX_S1:  code_d = S1;
      IDX_S2:  code_d = S2;
      IDX_S3:  code_d = S3;
      IDX_S4:  code_d = S4;
      IDX_S5:  code_d = S5;
      default: code_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= IDX_S0;
      dir_q  <= DIR_UP;
      code_q <= S0;
    end else begin
      idx_q  <= idx_d;
      dir_q  <= dir_d;
      code_q <= code_d;
    end
  end

  assign bus.seq = {dir_q, code_q};

`ifdef PRACTICA_FSM_ILLEGAL_RECOVER_EN
  illegal_idx_a: assert property (@(posedge clk) disable iff (!rst) idx_q <= IDX_LAST);
`endif

endmodule

// File: tb/tb_practica_fsm.sv
// Directed bench for practica_fsm: reset, up/down wrap, hold, reversal,
// async mid-sequence reset and a parameter-overridden second instance.
module tb_practica_fsm;
  import practica_fsm_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  practica_fsm_if a_if ();
  practica_fsm_if b_if ();

  practica_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  practica_fsm #(.S1(4'b1111), .S5(4'b0001)) dut_ovr (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SEQ_W-1:0] obs,
                       input logic [SEQ_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: seq=0x%h expected 0x%h", tag, obs, exp);
    end
    $display("vec %0d %s seq=0x%h exp=0x%h", vectors, tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    a_if.enable = 1'b0; a_if.up_down = 1'b0;
    b_if.enable = 1'b0; b_if.up_down = 1'b0;

    // Reset held for 5 cycles with enable low
    #2 rst = 1'b0;
    repeat (5) step();
    check("reset", a_if.seq, 5'h10);
    check("reset_ovr", b_if.seq, 5'h10);

    // Up count with wrap; override instance steps twice then holds
    rst = 1'b1;
    a_if.enable = 1'b1; a_if.up_down = 1'b1;
    b_if.enable = 1'b1; b_if.up_down = 1'b1;
    step(); check("up1", a_if.seq, 5'h12); check("ovr_up1", b_if.seq, 5'h1F);
    step(); check("up2", a_if.seq, 5'h13); check("ovr_up2", b_if.seq, 5'h13);
    b_if.enable = 1'b0;
    step(); check("up3", a_if.seq, 5'h15);
    step(); check("up4", a_if.seq, 5'h17);
    step(); check("up5", a_if.seq, 5'h1A);
    step(); check("up6_wrap", a_if.seq, 5'h10);
    check("ovr_hold", b_if.seq, 5'h13);

    // Down count from S0 with wrap to S5
    a_if.up_down = 1'b0;
    step(); check("dn1_wrap", a_if.seq, 5'h0A);
    step(); check("dn2", a_if.seq, 5'h07);
    step(); check("dn3", a_if.seq, 5'h05);
    step(); check("dn4", a_if.seq, 5'h03);
    step(); check("dn5", a_if.seq, 5'h02);
    step(); check("dn6", a_if.seq, 5'h00);

    // Go to S2, then hold while toggling up_down
    a_if.up_down = 1'b1;
    step(); check("to_s1", a_if.seq, 5'h12);
    step(); check("to_s2", a_if.seq, 5'h13);
    a_if.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_if.up_down = i[0];
      step(); check("hold", a_if.seq, 5'h13);
    end

    // Reversal at S4
    a_if.enable = 1'b1; a_if.up_down = 1'b1;
    step(); check("rev_s3", a_if.seq, 5'h15);
    step(); check("rev_s4", a_if.seq, 5'h17);
    a_if.up_down = 1'b0;
    step(); check("rev_dn_s3", a_if.seq, 5'h05);
    step(); check("rev_dn_s2", a_if.seq, 5'h03);

    // Async reset mid-sequence at S3, observed before the next edge
    a_if.up_down = 1'b1;
    step(); check("pre_rst_s3", a_if.seq, 5'h15);
    #2 rst = 1'b0;
    #1 check("async_rst", a_if.seq, 5'h10);
    check("async_rst_ovr", b_if.seq, 5'h10);
    step(); check("rst_held_edge", a_if.seq, 5'h10);

    // First enabled edge after release steps from S0
    rst = 1'b1;
    step(); check("post_rst_s1", a_if.seq, 5'h12);

`ifdef PRACTICA_FSM_ILLEGAL_RECOVER_EN
    a_if.enable = 1'b0;
    force dut.idx_q = 3'd7;
    #1 release dut.idx_q;
    step(); check("recover", a_if.seq, 5'h10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/practica_fsm.md
# practica_fsm

Six-state bidirectional sequence generator. On each enabled clock edge it steps forward or backward around a ring of six states and drives a 5-bit code on `seq`: the current state's 4-bit code plus a direction flag. It is a standalone lab-level block; `seq` feeds displays or downstream pattern logic directly from registers.

## Interface
- `S0`, default 4'b0000: output code of state 0 (reset state).
- `S1`, default 4'b0010: code of state 1.
- `S2`, default 4'b0011: code of state 2.
- `S3`, default 4'b0101: code of state 3.
- `S4`, default 4'b0111: code of state 4.
- `S5`, default 4'b1010: code of state 5.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `enable`  in  1  1 = advance one state this edge; 0 = hold.
- `up_down`  in  1  1 = step S0→S1→…→S5→S0; 0 = step S5→S4→…→S0→S5.
- `seq`  out  5  `{dir, code}`: bit 4 = direction of the last executed step (1 = up), bits 3:0 = current state's parameter code.

## Operation
- The state is held internally as a 3-bit index 0..5, not as the parameter code. The code is a registered lookup of the index.
- Up step: index+1, wrapping 5→0.
- Down step: index−1, wrapping 0→5.
- `enable=0`: index, code and dir all hold. `up_down` is ignored.
- `enable=1`: step in the `up_down` direction. `dir` takes `up_down`.
- Reset asserted: index=0, `seq = {1'b1, S0}`. This takes effect immediately, independent of `clk`, including mid-sequence.
- Index values 6 and 7 are illegal; see Configuration.
- Codes need not be distinct. Equal codes produce repeated outputs but leave the stepping unchanged.

## Timing
- Moore machine with a fully registered output: `seq` changes only on a rising `clk` edge or on reset assertion.
- Latency is one cycle. `enable`/`up_down` sampled at edge N are reflected on `seq` just after edge N.
- Reset release: the first edge with `rst=1` and `enable=1` performs the first step from S0.
- Direction reversal takes effect on the first edge at which the new `up_down` value is sampled. There is no extra hold cycle.

## Configuration
- `PRACTICA_FSM_ILLEGAL_RECOVER_EN` defined: an index of 6 or 7 forces index 0, with `seq={dir,S0}`, on the next edge regardless of `enable`. An assertion flags the event in simulation.
- Undefined: illegal indices hold their value and `seq` bits 3:0 output 4'b0000. There is no recovery logic.

## Structure
- Shared package `practica_fsm_pkg` holds:
  - the default state codes;
  - the state index constants `IDX_S0`..`IDX_S5` and `IDX_LAST=5`;
  - direction constants `DIR_UP=1`, `DIR_DOWN=0`;
  - the code width (4) and output width (5).
- One natural sub-module, `practica_fsm_next`: combinational next-index logic (index, enable, up_down → next index, next dir), including the wrap logic. The top level keeps the registers and the code lookup.

## Test plan
- Reset: hold `rst=0` for 5 cycles with `enable=0` → `seq=5'b1_0000`. Assert `rst` mid-sequence at S3 → `seq=5'b1_0000` immediately, before the next edge.
- Up count: release reset, `enable=1`, `up_down=1`, 6 edges → `seq` codes 2,3,5,7,10,0 (0x12,0x13,0x15,0x17,0x1A,0x10).
- Down count from S0: `up_down=0`, 6 edges → 10,7,5,3,2,0 with bit 4 = 0 (0x0A,0x07,0x05,0x03,0x02,0x00).
- Hold: at S2 with `enable=0` for 4 edges, toggling `up_down` → `seq` stays 0x13.
- Reversal: up to S4 (0x17), then `up_down=0` → next edge 0x05, then 0x03.
- Parameter override: S1=4'b1111, S5=4'b0001, up 2 edges → 0x1F, 0x13. With the macro defined, force index=7 → next edge `seq` code = S0.
